// File: rtl/draw_pkg.sv
// Shared state encoding, geometry defaults and VGA pixel type for the draw scheduler.
package draw_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W     = 3;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;

  typedef enum logic [2:0] {
    IDLE, CLR_GO, CLEAR, DRW_GO, DRAW, FINISH, FAULT
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
  } vga_pix_t;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int w, input int h);
    return (int'({24'd0, x}) < w) && (int'({25'd0, y}) < h);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; expired marks the TIMEOUT-th ticking cycle of a phase.
module phase_watchdog #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam logic [15:0] LAST = TIMEOUT - 16'd1;

  logic [15:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled phase cannot wrap back to a fresh budget.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (tick && cnt_q != LAST) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = tick && (cnt_q == LAST);

endmodule

// File: rtl/draw_scheduler.sv
// Sequences screen-clear then circle engines onto one VGA write port, with per-phase timeout.
// Optional off-screen pixel suppression: define DRAW_SCHED_BOUNDS_CHECK_EN.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int                  SCREEN_W     = SCREEN_W_DEF,
  parameter int                  SCREEN_H     = SCREEN_H_DEF,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000,
  parameter logic [15:0]         TIMEOUT      = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COLOUR_W-1:0] draw_colour,
  output logic                clr_en,
  input  logic [X_W-1:0]      clr_x,
  input  logic [Y_W-1:0]      clr_y,
  input  logic                clr_plt,
  input  logic                clr_done,
  output logic                circ_en,
  input  logic [X_W-1:0]      circ_x,
  input  logic [Y_W-1:0]      circ_y,
  input  logic                circ_plt,
  input  logic                circ_done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done,
  output logic                error
);

  state_e              state_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                clr_en_q, circ_en_q, busy_q, done_q, error_q;
  vga_pix_t            pix_q, pix_d;
  logic                wd_clr, wd_tick, expired, phase_done, timeout;
  logic                clr_ok, circ_ok, clr_on, circ_on;

  assign wd_clr  = (state_q == CLR_GO) || (state_q == DRW_GO);
  assign wd_tick = (state_q == CLEAR)  || (state_q == DRAW);

  phase_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .tick    (wd_tick),
    .expired (expired)
  );

  // Only the owning engine's done counts, and it beats a same-cycle expiry.
  assign phase_done = ((state_q == CLEAR) && clr_done) || ((state_q == DRAW) && circ_done);
  assign timeout    = expired && !phase_done;

  assign clr_on  = on_screen(clr_x, clr_y, SCREEN_W, SCREEN_H);
  assign circ_on = on_screen(circ_x, circ_y, SCREEN_W, SCREEN_H);

`ifdef DRAW_SCHED_BOUNDS_CHECK_EN
  assign clr_ok  = clr_on;
  assign circ_ok = circ_on;
`else
  logic unused_bounds;
  assign clr_ok        = 1'b1;
  assign circ_ok       = 1'b1;
  assign unused_bounds = clr_on ^ circ_on;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      colour_q  <= '0;
      clr_en_q  <= 1'b0;
      circ_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      clr_en_q  <= 1'b0;
      circ_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE, FAULT: if (start) begin
          state_q  <= CLR_GO;
          colour_q <= draw_colour;
          error_q  <= 1'b0;
          busy_q   <= 1'b1;
          clr_en_q <= 1'b1;
        end
        CLR_GO: state_q <= CLEAR;
        CLEAR: if (clr_done) begin
          state_q   <= DRW_GO;
          circ_en_q <= 1'b1;
        end else if (expired) begin
          state_q <= FAULT;
          error_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        DRW_GO: state_q <= DRAW;
        DRAW: if (circ_done) begin
          state_q <= FINISH;
          done_q  <= 1'b1;
        end else if (expired) begin
          state_q <= FAULT;
          error_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Non-owning engine is simply not selected, so its pixels vanish.
  always_comb begin
    pix_d      = pix_q;
    pix_d.plot = 1'b0;
    case (state_q)
      CLEAR:   pix_d = '{x: clr_x,  y: clr_y,  colour: CLEAR_COLOUR, plot: clr_plt & clr_ok};
      DRAW:    pix_d = '{x: circ_x, y: circ_y, colour: colour_q,     plot: circ_plt & circ_ok};
      default: ;
    endcase
    if (timeout) pix_d.plot = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_q <= '0;
    else      pix_q <= pix_d;
  end

  assign clr_en     = clr_en_q;
  assign circ_en    = circ_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_colour = pix_q.colour;
  assign vga_plot   = pix_q.plot;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: vector table, random pixel streams vs a phase-level model, timeout/reset sequences.
module tb_draw_scheduler;

  localparam int TO0 = 65535;
  localparam int TO1 = 100;
`ifdef DRAW_SCHED_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif
  localparam int P_IDLE = 0, P_CGO = 1, P_CLR = 2, P_DGO = 3, P_DRW = 4, P_FIN = 5, P_FLT = 6;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, start_t = 1'b0;
  logic [2:0] draw_colour = '0;
  logic [7:0] clr_x = '0, circ_x = '0;
  logic [6:0] clr_y = '0, circ_y = '0;
  logic       clr_plt = 1'b0, clr_done = 1'b0, circ_plt = 1'b0, circ_done = 1'b0;

  logic       o_clr_en[2], o_circ_en[2], o_plot[2], o_busy[2], o_done[2], o_err[2];
  logic [7:0] o_x[2];
  logic [6:0] o_y[2];
  logic [2:0] o_col[2];

  always #5 clk = ~clk;

  draw_scheduler dut0 (
    .clk(clk), .rst(rst), .start(start), .draw_colour(draw_colour),
    .clr_en(o_clr_en[0]), .clr_x(clr_x), .clr_y(clr_y), .clr_plt(clr_plt), .clr_done(clr_done),
    .circ_en(o_circ_en[0]), .circ_x(circ_x), .circ_y(circ_y), .circ_plt(circ_plt), .circ_done(circ_done),
    .vga_x(o_x[0]), .vga_y(o_y[0]), .vga_colour(o_col[0]), .vga_plot(o_plot[0]),
    .busy(o_busy[0]), .done(o_done[0]), .error(o_err[0])
  );

  draw_scheduler #(.TIMEOUT(16'd100)) dut1 (
    .clk(clk), .rst(rst), .start(start_t), .draw_colour(draw_colour),
    .clr_en(o_clr_en[1]), .clr_x(clr_x), .clr_y(clr_y), .clr_plt(clr_plt), .clr_done(clr_done),
    .circ_en(o_circ_en[1]), .circ_x(circ_x), .circ_y(circ_y), .circ_plt(circ_plt), .circ_done(circ_done),
    .vga_x(o_x[1]), .vga_y(o_y[1]), .vga_colour(o_col[1]), .vga_plot(o_plot[1]),
    .busy(o_busy[1]), .done(o_done[1]), .error(o_err[1])
  );

  int total = 0, bad = 0;

  task automatic chkn(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d @%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input int i, input logic act, input logic exp);
    chkn(nm, i, int'(act), int'(exp));
  endtask

  // Phase-level reference: where each DUT is in the sequence and how long it has been there.
  int         m_ph[2], m_el[2];
  logic [2:0] m_col[2];
  logic       m_err[2], e_plot[2];
  logic [7:0] e_x[2];
  logic [6:0] e_y[2];
  logic [2:0] e_c[2];
  int         n_clr[2], n_circ[2], n_done[2];

  function automatic logic inb(input logic [7:0] x, input logic [6:0] y);
    return BCHK ? ((int'(x) < 160) && (int'(y) < 120)) : 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_IDLE; m_el[i] = 0; m_col[i] = '0; m_err[i] = 1'b0;
      e_plot[i] = 1'b0; e_x[i] = '0; e_y[i] = '0; e_c[i] = '0;
    end
  endtask

  task automatic model_step(input int i, input logic st);
    int  to;
    bit  fin, tout;
    to = (i == 0) ? TO0 : TO1;
    e_plot[i] = 1'b0;
    if (m_ph[i] == P_CLR || m_ph[i] == P_DRW) begin
      fin  = (m_ph[i] == P_CLR) ? clr_done : circ_done;
      tout = !fin && (m_el[i] + 1 >= to);
      if (m_ph[i] == P_CLR) begin
        e_x[i] = clr_x; e_y[i] = clr_y; e_c[i] = 3'b000;
        e_plot[i] = clr_plt && inb(clr_x, clr_y) && !tout;
      end else begin
        e_x[i] = circ_x; e_y[i] = circ_y; e_c[i] = m_col[i];
        e_plot[i] = circ_plt && inb(circ_x, circ_y) && !tout;
      end
      m_el[i]++;
      if (fin)       m_ph[i] = (m_ph[i] == P_CLR) ? P_DGO : P_FIN;
      else if (tout) begin m_ph[i] = P_FLT; m_err[i] = 1'b1; end
    end else begin
      case (m_ph[i])
        P_IDLE, P_FLT: if (st) begin m_ph[i] = P_CGO; m_col[i] = draw_colour; m_err[i] = 1'b0; end
        P_CGO:   begin m_ph[i] = P_CLR; m_el[i] = 0; end
        P_DGO:   begin m_ph[i] = P_DRW; m_el[i] = 0; end
        default: m_ph[i] = P_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk1("clr_en", i, o_clr_en[i], m_ph[i] == P_CGO);
      chk1("circ_en", i, o_circ_en[i], m_ph[i] == P_DGO);
      chk1("done", i, o_done[i], m_ph[i] == P_FIN);
      chk1("busy", i, o_busy[i], !(m_ph[i] == P_IDLE || m_ph[i] == P_FLT));
      chk1("error", i, o_err[i], m_err[i]);
      chk1("vga_plot", i, o_plot[i], e_plot[i]);
      if (e_plot[i]) begin
        chkn("vga_x", i, int'(o_x[i]), int'(e_x[i]));
        chkn("vga_y", i, int'(o_y[i]), int'(e_y[i]));
        chkn("vga_colour", i, int'(o_col[i]), int'(e_c[i]));
      end
    end
  endtask

  task automatic chk_zero(input int i);
    chk1("rst_clr_en", i, o_clr_en[i], 1'b0);
    chk1("rst_circ_en", i, o_circ_en[i], 1'b0);
    chk1("rst_done", i, o_done[i], 1'b0);
    chk1("rst_busy", i, o_busy[i], 1'b0);
    chk1("rst_error", i, o_err[i], 1'b0);
    chk1("rst_plot", i, o_plot[i], 1'b0);
    chkn("rst_x", i, int'(o_x[i]), 0);
    chkn("rst_y", i, int'(o_y[i]), 0);
    chkn("rst_colour", i, int'(o_col[i]), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_step(0, start);
      model_step(1, start_t);
    end
    @(negedge clk);
    compare_all();
    for (int i = 0; i < 2; i++) begin
      n_clr[i]  += int'(o_clr_en[i]);
      n_circ[i] += int'(o_circ_en[i]);
      n_done[i] += int'(o_done[i]);
    end
  endtask

  task automatic idle_pix();
    clr_x = '0; clr_y = '0; clr_plt = 1'b0;
    circ_x = '0; circ_y = '0; circ_plt = 1'b0;
  endtask

  task automatic rand_pix();
    clr_x = 8'($urandom); clr_y = 7'($urandom); clr_plt = 1'($urandom);
    circ_x = 8'($urandom); circ_y = 7'($urandom); circ_plt = 1'($urandom);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin n_clr[i] = 0; n_circ[i] = 0; n_done[i] = 0; end
  endtask

  typedef struct {
    logic       drw;
    logic [7:0] cx; logic [6:0] cy; logic cp;
    logic [7:0] dx; logic [6:0] dy; logic dp;
    logic [7:0] ex; logic [6:0] ey; logic [2:0] ec; logic ep;
  } vec_t;

  vec_t vec[9];
  int   fault_n;

  initial begin
    vec[0] = '{1'b0, 8'd5,   7'd7,   1'b1, 8'd9,   7'd9,   1'b1, 8'd5,   7'd7,   3'd0, 1'b1};
    vec[1] = '{1'b0, 8'd10,  7'd20,  1'b0, 8'd1,   7'd1,   1'b1, 8'd10,  7'd20,  3'd0, 1'b0};
    vec[2] = '{1'b0, 8'd159, 7'd119, 1'b1, 8'd0,   7'd0,   1'b0, 8'd159, 7'd119, 3'd0, 1'b1};
    vec[3] = '{1'b0, 8'd200, 7'd100, 1'b1, 8'd0,   7'd0,   1'b1, 8'd200, 7'd100, 3'd0, !BCHK};
    vec[4] = '{1'b1, 8'd0,   7'd0,   1'b1, 8'd160, 7'd10,  1'b1, 8'd160, 7'd10,  3'd5, !BCHK};
    vec[5] = '{1'b1, 8'd3,   7'd4,   1'b1, 8'd12,  7'd34,  1'b0, 8'd12,  7'd34,  3'd5, 1'b0};
    vec[6] = '{1'b1, 8'd0,   7'd0,   1'b0, 8'd159, 7'd119, 1'b1, 8'd159, 7'd119, 3'd5, 1'b1};
    vec[7] = '{1'b1, 8'd0,   7'd0,   1'b0, 8'd20,  7'd120, 1'b1, 8'd20,  7'd120, 3'd5, !BCHK};
    vec[8] = '{1'b1, 8'd0,   7'd0,   1'b1, 8'd0,   7'd0,   1'b1, 8'd0,   7'd0,   3'd5, 1'b1};

    model_reset();
    clr_counts();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) chk_zero(i);
    rst = 1'b1;

    // Vector table through one clear/draw sequence on dut0.
    draw_colour = 3'b101; start = 1'b1; tick(); start = 1'b0; draw_colour = 3'b010;
    chk1("tbl_clr_en", 0, o_clr_en[0], 1'b1);
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k > 0 && vec[k].drw && !vec[k-1].drw) begin
        idle_pix(); clr_done = 1'b1; tick(); clr_done = 1'b0;
        chk1("tbl_circ_en", 0, o_circ_en[0], 1'b1);
        tick();
      end
      clr_x = vec[k].cx; clr_y = vec[k].cy; clr_plt = vec[k].cp;
      circ_x = vec[k].dx; circ_y = vec[k].dy; circ_plt = vec[k].dp;
      tick();
      chk1("tbl_plot", 0, o_plot[0], vec[k].ep);
      if (vec[k].ep) begin
        chkn("tbl_x", 0, int'(o_x[0]), int'(vec[k].ex));
        chkn("tbl_y", 0, int'(o_y[0]), int'(vec[k].ey));
        chkn("tbl_colour", 0, int'(o_col[0]), int'(vec[k].ec));
      end
    end
    idle_pix(); circ_done = 1'b1; tick(); circ_done = 1'b0;
    chk1("tbl_done", 0, o_done[0], 1'b1);
    tick();
    chk1("tbl_idle", 0, o_busy[0], 1'b0);

    // Long run: dut0 completes, dut1 (short timeout) faults, restarts and faults again.
    clr_counts();
    draw_colour = 3'($urandom); start = 1'b1; start_t = 1'b1; tick();
    start = 1'b0; start_t = 1'b0;
    fault_n = 0;
    for (int n = 1; n <= 19360; n++) begin
      rand_pix();
      clr_done  = (n == 19360);
      circ_done = (n == 50);
      start     = (n == 70);
      start_t   = (n == 250);
      tick();
      if (fault_n == 0 && o_err[1]) begin
        fault_n = n;
        chk1("t_busy_at_fault", 1, o_busy[1], 1'b0);
      end
      if (n == 250) chk1("t_err_cleared", 1, o_err[1], 1'b0);
    end
    chkn("t_fault_cycle", 1, fault_n, 101);
    clr_done = 1'b0; circ_done = 1'b0; start = 1'b0; start_t = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      rand_pix(); circ_done = (n == 500); tick();
    end
    circ_done = 1'b0; idle_pix(); tick();
    chkn("run_clr_en_pulses", 0, n_clr[0], 1);
    chkn("run_circ_en_pulses", 0, n_circ[0], 1);
    chkn("run_done_pulses", 0, n_done[0], 1);
    chk1("run_error", 0, o_err[0], 1'b0);

    // Done on the exact expiry cycle wins, in both phases (dut1).
    start_t = 1'b1; tick(); start_t = 1'b0;
    for (int n = 1; n <= 101; n++) begin rand_pix(); clr_done = (n == 101); tick(); end
    clr_done = 1'b0;
    chk1("tie_clr_error", 1, o_err[1], 1'b0);
    chk1("tie_clr_circ_en", 1, o_circ_en[1], 1'b1);
    for (int n = 1; n <= 101; n++) begin rand_pix(); circ_done = (n == 101); tick(); end
    circ_done = 1'b0;
    chk1("tie_drw_done", 1, o_done[1], 1'b1);
    chk1("tie_drw_error", 1, o_err[1], 1'b0);
    idle_pix(); tick();

    // Reset in the middle of DRAW, with a stray start while busy.
    clr_counts();
    draw_colour = 3'b011; start = 1'b1; tick(); start = 1'b0;
    repeat (5) begin rand_pix(); tick(); end
    clr_done = 1'b1; tick(); clr_done = 1'b0;
    repeat (3) begin rand_pix(); tick(); end
    start = 1'b1; rand_pix(); tick(); start = 1'b0;
    chk1("busy_start_ignored", 0, o_busy[0], 1'b1);
    rand_pix(); circ_plt = 1'b1; tick();
    #2 rst = 1'b0;
    #1 model_reset();
    for (int i = 0; i < 2; i++) chk_zero(i);
    circ_done = 1'b1; tick(); circ_done = 1'b0;
    rst = 1'b1;
    repeat (5) begin rand_pix(); tick(); end
    chkn("rst_no_done", 0, n_done[0], 0);
    chkn("rst_one_clr_en", 0, n_clr[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
